alu_result_uart_tx: RTL and testbench
=====================================

Name: alu_result_uart_tx

Overview:
Downstream stage of the 4-bit operand ALU. Captures each 8-bit ALU result on a valid strobe into a small FIFO. Serialises results out of one pin as UART 8N1 frames, LSB first, for an off-chip host/logic analyser. Sits between the ALU's registered result and a spare uio output pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
DEPTH, 4, FIFO entries; power of two, 2..16.
CW, 3, count width = log2(DEPTH)+1.

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
res_data  input  8  ALU result byte.
res_valid  input  1  res_data valid this cycle.
res_ready  output  1  FIFO can accept; equals (count != DEPTH).
clr_ovf  input  1  synchronous clear of overflow flag.
tx  output  1  UART line; idle high; registered.
busy  output  1  high while a frame is in progress (state != IDLE).
fifo_count  output  CW  entries held, 0..DEPTH.
overflow  output  1  sticky: a result was presented while full.

Behaviour:
- Reset (rst_n low, async): tx=1, busy=0, fifo_count=0, overflow=0, res_ready=1; rd/wr pointers, shift reg, bit/baud counters cleared; state=IDLE. Reset mid-frame aborts the frame: tx high immediately, FIFO contents discarded.
- Push: res_valid && res_ready at edge -> res_data written at wr_ptr, wr_ptr wraps modulo DEPTH, count+1.
- Full: res_ready=0 even if a pop occurs the same cycle; res_valid while full -> byte dropped, overflow=1 next edge, held until clr_ovf. clr_ovf and a new overflow event in the same cycle -> overflow stays 1 (set wins).
- Pop: only in IDLE with count != 0; head byte loaded into shift reg, rd_ptr wraps, count-1. Push and pop in the same cycle (not full) -> count unchanged.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  IDLE: tx=1; on count!=0 pop, go START, baud_cnt=0.
  START: tx=0 for CLKS_PER_BIT cycles.
  DATA: tx=shift[0]; after CLKS_PER_BIT cycles shift right and bit_idx+1; after bit 7 go STOP.
  STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx is registered: start bit appears on the edge of the pop. Frame = 10*CLKS_PER_BIT cycles.
- Back-to-back frames are separated by exactly one IDLE cycle (tx high).
- Latency: byte pushed at edge N -> pop at edge N+1 if IDLE -> tx falls at edge N+1.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps; no fractional divisor.
- busy=1 in START/DATA/STOP, 0 in IDLE.

Test Plan:
- Reset state: hold rst_n low -> tx=1, busy=0, fifo_count=0, res_ready=1, overflow=0.
- Single frame, CLKS_PER_BIT=4: push 0xA5 -> tx low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, stop high 4 clks; busy high exactly 40 clks; decoded byte 0xA5.
- Fill and overflow, DEPTH=4: push 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles -> first byte popped immediately; 0x02-0x05 fill FIFO; res_ready=0; 0x06 dropped; overflow=1; tx emits 01,02,03,04,05 with 1-clk gaps; clr_ovf pulse -> overflow=0.
- Simultaneous push/pop: count=1 while IDLE, push in the same cycle as the pop -> fifo_count stays 1, order preserved.
- Pointer wrap: push/transmit 10 sequential bytes 0x10..0x19 with count never exceeding 3 -> all 10 received in order.
- Reset mid-frame: assert rst_n during DATA bit 3 -> tx=1 asynchronously, count=0; after release with no pushes, tx stays high and busy=0.

Source files
------------

// File: rtl/alu_result_uart_tx.sv
// ALU result capture FIFO feeding a UART 8N1 transmitter (LSB first, idle-high line).
// One spare output pin carries each buffered result byte to an off-chip host.
module alu_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CW           = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    res_data,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic          clr_ovf,
  output logic          tx,
  output logic          busy,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int unsigned    PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0]    BaudMax = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  Full    = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      mem_q [DEPTH];
  logic            push, pop;

  assign res_ready  = (count_q != Full);
  assign push       = res_valid && res_ready;
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  // Transmit FSM; tx_d is the line level for the state being entered.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          state_d   = StStart;
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_q == BaudMax) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          state_d = StIdle;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // A drop while full takes priority over a same-cycle clear.
    if (res_valid && !res_ready) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= res_data;
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx: frame timing, FIFO fill/overflow, wrap, async reset.
// A negedge UART decoder turns the tx line into received bytes and frame start times.
module tb_alu_result_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  alu_result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (4),
    .CW          (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .clr_ovf   (clr_ovf),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // UART receiver model
  logic [7:0] rx_bytes [$];
  int         rx_starts [$];
  int         cyc = 0;
  int         rx_cnt = 0;
  logic       rx_active = 1'b0;
  logic [7:0] rx_shift = 8'h00;
  int         frame_bad = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == CPB / 2 && tx !== 1'b0) frame_bad <= frame_bad + 1;
      if (rx_cnt % CPB == CPB / 2 && rx_cnt > CPB && rx_cnt < 9 * CPB)
        rx_shift <= {tx, rx_shift[7:1]};
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        if (tx !== 1'b1) frame_bad <= frame_bad + 1;
        rx_bytes.push_back(rx_shift);
        rx_active <= 1'b0;
      end
    end
  end

  int max_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    res_data  = b;
    res_valid = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget && rx_bytes.size() < n; i++) begin
      @(negedge clk);
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    check_eq("rx_wait", 32'(rx_bytes.size() >= n), 1);
  endtask

  initial begin
    int         base;
    int         bad;
    int         tx_bad;
    int         busy_bad;
    logic [9:0] frame;
    logic [7:0] exp_b;

    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_data  = 8'h00;
    clr_ovf   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_ready", res_ready, 1);
    check_eq("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame 0xA5, bit-exact waveform
    base  = rx_bytes.size();
    frame = {1'b1, 8'hA5, 1'b0};
    push(8'hA5);
    @(negedge clk);
    check_eq("pre_pop_tx", tx, 1);
    check_eq("pre_pop_count", fifo_count, 1);
    tx_bad   = 0;
    busy_bad = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      if (tx !== frame[k / CPB]) tx_bad++;
      if (busy !== 1'b1) busy_bad++;
    end
    check_eq("a5_wave", tx_bad, 0);
    check_eq("a5_busy_hi", busy_bad, 0);
    @(negedge clk);
    check_eq("a5_busy_end", busy, 0);
    check_eq("a5_tx_end", tx, 1);
    wait_rx(base + 1, 10);
    check_eq("a5_byte", rx_bytes[base], 8'hA5);

    // Fill and overflow
    base = rx_bytes.size();
    for (int i = 0; i < 6; i++) begin
      res_data  = 8'(i + 1);
      res_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    check_eq("full_ready", res_ready, 0);
    check_eq("full_count", fifo_count, 4);
    check_eq("full_ovf", overflow, 1);
    wait_rx(base + 5, 400);
    repeat (60) @(negedge clk);
    check_eq("fill_nbytes", rx_bytes.size(), base + 5);
    for (int i = 0; i < 5; i++) begin
      exp_b = 8'(i + 1);
      check_eq("fill_byte", rx_bytes[base + i], exp_b);
    end
    for (int i = 0; i < 4; i++)
      check_eq("fill_gap", rx_starts[base + i + 1] - rx_starts[base + i], 10 * CPB + 1);
    check_eq("ovf_held", overflow, 1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    check_eq("ovf_clr", overflow, 0);

    // Push in the same cycle as a pop
    base = rx_bytes.size();
    push(8'h3C);
    push(8'hC3);
    check_eq("pp_count", fifo_count, 1);
    check_eq("pp_busy", busy, 1);
    wait_rx(base + 2, 120);
    check_eq("pp_byte0", rx_bytes[base], 8'h3C);
    check_eq("pp_byte1", rx_bytes[base + 1], 8'hC3);

    // Pointer wrap with shallow occupancy
    base    = rx_bytes.size();
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      push(8'(8'h10 + i));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (i % 3 == 2 || i == 9) wait_rx(base + i + 1, 200);
    end
    check_eq("wrap_max_le3", 32'(max_cnt <= 3), 1);
    for (int i = 0; i < 10; i++) begin
      exp_b = 8'(8'h10 + i);
      check_eq("wrap_byte", rx_bytes[base + i], exp_b);
    end

    // Reset in the middle of DATA bit 3 of 0x52 (bit 3 = 0)
    repeat (12) @(negedge clk);
    push(8'h52);
    push(8'h77);
    repeat (18) @(posedge clk);
    #3;
    base = rx_bytes.size();
    check_eq("mid_tx_low", tx, 0);
    check_eq("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_tx", tx, 1);
    check_eq("arst_count", fifo_count, 0);
    check_eq("arst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_eq("post_rst_idle", bad, 0);
    check_eq("post_rst_nobytes", rx_bytes.size(), base);
    check_eq("frame_bits", frame_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
